bin_loader: RTL and testbench
=============================

BIN_LOADER -- requirements
Module: bin_loader

Interface
REQ-001 SHALL have parameter START_PC, default 12'o0200: PC value loaded on successful completion.
REQ-002 SHALL have parameter DEFAULT_ORIGIN, default 12'o0000: load address used until the first origin frame.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port btnCpuReset, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
REQ-006 SHALL have port byte_valid, input, 1: byte_data holds a valid object-file frame.
REQ-007 SHALL have port byte_data, input, 8: object-file frame; bit7 marks leader/trailer, bit6 marks origin, bits[5:0] carry the payload.
REQ-008 SHALL have port byte_ready, output, 1: loader accepts the frame this cycle.
REQ-009 SHALL have port mem_address, output, 12: memory write address.
REQ-010 SHALL have port mem_write_data, output, 12: memory write data.
REQ-011 SHALL have port mem_write_enable, output, 1: memory write request.
REQ-012 SHALL have port mem_finished, input, 1: memory has completed the current access.
REQ-013 SHALL have port pc_load, output, 1: single-cycle PC load strobe.
REQ-014 SHALL have port pc_load_value, output, 12: PC value; constant START_PC.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE, DONE and ERR.
REQ-016 SHALL have port done, output, 1: load completed.
REQ-017 SHALL have port error, output, 1: malformed stream detected.
REQ-018 SHALL have port word_count, output, 12: number of data words written in the current load; wraps modulo 4096.

Function
REQ-019 SHALL transfer a frame only on a cycle where byte_valid and byte_ready are both high.
REQ-020 SHALL hold byte_ready high only in states LEADER, HIGH and LOW.
REQ-021 SHALL implement the states IDLE, LEADER, HIGH, LOW, WRITE, WAIT_MEM, DONE and ERR.
REQ-022 On start in IDLE, DONE or ERR: go to LEADER; clear word_count, done and error; set the address register to DEFAULT_ORIGIN; clear the data_seen flag.
REQ-023 In LEADER: discard frames with bit7=1; a frame with bit7=0 is captured as a high frame and the state goes to LOW.
REQ-024 In HIGH: a frame with bit7=1 and data_seen=1 goes to DONE; a frame with bit7=1 and data_seen=0 is discarded and the state stays in HIGH; a frame with bit7=0 is captured as the high frame and the state goes to LOW.
REQ-025 In LOW: a frame with bit7=1 or bit6=1 goes to ERR; otherwise word = {high[5:0], low[5:0]}.
REQ-026 Origin case: if the high frame had bit6=1, the address register SHALL load word and the state returns to HIGH with no memory write.
REQ-027 Data case: if the high frame had bit6=0, the state goes to WRITE on the next cycle.
REQ-028 In WRITE: drive mem_write_enable=1, mem_address=address register and mem_write_data=word; then go to WAIT_MEM.
REQ-029 In WAIT_MEM: hold mem_write_enable, mem_address and mem_write_data stable until mem_finished is sampled high.
REQ-030 On that mem_finished cycle: drop mem_write_enable next cycle, increment the address register modulo 4096 (7777 wraps to 0000), increment word_count, set data_seen and go to HIGH.
REQ-031 SHALL ignore mem_finished in every state other than WAIT_MEM.
REQ-032 Write latency SHALL be: mem_write_enable rises exactly 2 cycles after the clock edge that accepts the low frame.
REQ-033 On entry to DONE: pulse pc_load for exactly 1 cycle and hold done=1 until the next start.
REQ-034 On entry to ERR: hold error=1 and never assert pc_load.
REQ-035 In both DONE and ERR: byte_ready=0.
REQ-036 A start pulse while busy SHALL be ignored.
REQ-037 Each checksum word in the stream SHALL be written to memory as ordinary data; no checksum is stripped or checked.

Reset
REQ-038 On btnCpuReset=0, the block SHALL immediately enter IDLE, regardless of the current state, including mid-write.
REQ-039 Outputs under reset SHALL be: byte_ready=0, mem_write_enable=0, pc_load=0, busy=0, done=0, error=0, mem_address=0, mem_write_data=0, word_count=0.
REQ-040 An in-flight memory write SHALL be abandoned on reset without completing.

Verification
REQ-041 Stream 0200 0200 0102 0000 0076 0001 0200 -> one write 7601 to address 0200; word_count=1; pc_load pulses once with value 0200; done=1.
REQ-042 Origin frame pair 0177 0077, then data pairs 0001 0002 and 0003 0004 -> writes 0102 at 7777, then 0304 at 0000 (address wrap).
REQ-043 mem_finished held low for 20 cycles after WRITE -> mem_write_enable, mem_address and mem_write_data are stable throughout; byte_ready=0 throughout; the write completes on the first mem_finished.
REQ-044 High frame 0001 followed by trailer 0200 -> ERR; error=1; no write; no pc_load.
REQ-045 btnCpuReset asserted while in WAIT_MEM -> all outputs at their reset values in the same cycle; a later start performs a clean load.
REQ-046 byte_valid toggled randomly during REQ-041's stream -> identical memory writes and identical word_count.

Source files
------------

// File: rtl/bin_loader.sv
// Object-file (binary paper-tape style) loader: assembles 6-bit frame pairs into
// 12-bit words, handles origin frames, writes data words to memory, then loads the PC.
module bin_loader #(
    parameter logic [11:0] START_PC       = 12'o0200,
    parameter logic [11:0] DEFAULT_ORIGIN = 12'o0000
) (
    input  logic        clk,
    input  logic        btnCpuReset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [11:0] mem_address,
    output logic [11:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic        mem_finished,
    output logic        pc_load,
    output logic [11:0] pc_load_value,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [11:0] word_count
);

    typedef enum logic [2:0] {
        IDLE, LEADER, HIGH, LOW, WRITE, WAIT_MEM, DONE, ERR
    } state_t;

    state_t      state, next_state;
    logic [6:0]  high_q;
    logic [11:0] word_q;
    logic [11:0] addr_q;
    logic        data_seen;
    logic        mem_we_q;
    logic        pc_load_q;

    logic xfer, start_ok, mem_done;
    logic [11:0] word;

    assign xfer     = byte_valid && byte_ready;
    assign start_ok = start && (state == IDLE || state == DONE || state == ERR);
    // Completion only counts once the write strobe is actually visible to memory.
    assign mem_done = (state == WAIT_MEM) && mem_we_q && mem_finished;
    assign word     = {high_q[5:0], byte_data[5:0]};

    assign mem_write_enable = mem_we_q;
    assign pc_load          = pc_load_q;
    assign pc_load_value    = START_PC;

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) state <= IDLE;
        else              state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (start_ok) next_state = LEADER;
            LEADER: if (xfer && !byte_data[7]) next_state = LOW;
            HIGH: begin
                if (xfer) begin
                    if (!byte_data[7])  next_state = LOW;
                    else if (data_seen) next_state = DONE;
                end
            end
            LOW: begin
                if (xfer) begin
                    if (byte_data[7] || byte_data[6]) next_state = ERR;
                    else if (high_q[6])               next_state = HIGH;
                    else                              next_state = WRITE;
                end
            end
            WRITE:    next_state = WAIT_MEM;
            WAIT_MEM: if (mem_done) next_state = HIGH;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == LEADER) || (state == HIGH) || (state == LOW);
        busy       = !((state == IDLE) || (state == DONE) || (state == ERR));
        done       = (state == DONE);
        error      = (state == ERR);
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            high_q         <= '0;
            word_q         <= '0;
            addr_q         <= '0;
            data_seen      <= 1'b0;
            word_count     <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_we_q       <= 1'b0;
            pc_load_q      <= 1'b0;
        end else begin
            mem_we_q  <= (state == WAIT_MEM) && !mem_done;
            pc_load_q <= (state == HIGH) && xfer && byte_data[7] && data_seen;
            if (start_ok) begin
                word_count <= '0;
                addr_q     <= DEFAULT_ORIGIN;
                data_seen  <= 1'b0;
            end
            if ((state == LEADER || state == HIGH) && xfer && !byte_data[7])
                high_q <= byte_data[6:0];
            if (state == LOW && xfer && !byte_data[7] && !byte_data[6]) begin
                if (high_q[6]) addr_q <= word;
                else           word_q <= word;
            end
            if (state == WRITE) begin
                mem_address    <= addr_q;
                mem_write_data <= word_q;
            end
            if (mem_done) begin
                addr_q     <= addr_q + 12'd1;
                word_count <= word_count + 12'd1;
                data_seen  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bin_loader.sv
// Directed bench for bin_loader: normal load, origin wrap, stalled write,
// malformed stream, reset mid-write and gapped byte_valid.
module tb_bin_loader;

    logic        clk = 1'b0;
    logic        btnCpuReset = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic [11:0] mem_address;
    logic [11:0] mem_write_data;
    logic        mem_write_enable;
    logic        mem_finished = 1'b0;
    logic        pc_load;
    logic [11:0] pc_load_value;
    logic        busy;
    logic        done;
    logic        error;
    logic [11:0] word_count;

    int total = 0;
    int bad = 0;
    logic        ack_en = 1'b1;
    int          n_writes = 0;
    logic [11:0] log_addr [16];
    logic [11:0] log_data [16];
    logic [7:0]  s41 [7] = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o076, 8'o001, 8'o200};

    always #5 clk = ~clk;

    bin_loader #(.START_PC(12'o0200), .DEFAULT_ORIGIN(12'o0000)) dut (
        .clk(clk), .btnCpuReset(btnCpuReset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_finished(mem_finished),
        .pc_load(pc_load), .pc_load_value(pc_load_value), .busy(busy),
        .done(done), .error(error), .word_count(word_count)
    );

    // Memory model: acknowledges a visible write with a one-cycle mem_finished pulse.
    always @(negedge clk) begin
        if (mem_finished) mem_finished = 1'b0;
        else if (ack_en && mem_write_enable) begin
            mem_finished = 1'b1;
            if (n_writes < 16) begin
                log_addr[n_writes] = mem_address;
                log_data[n_writes] = mem_write_data;
            end
            n_writes++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) chk("send_timeout", {31'd0, byte_ready}, 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_we"},    {31'd0, mem_write_enable}, 32'd0);
        chk({tag, "_pc"},    {31'd0, pc_load}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_err"},   {31'd0, error}, 32'd0);
        chk({tag, "_addr"},  {20'd0, mem_address}, 32'd0);
        chk({tag, "_data"},  {20'd0, mem_write_data}, 32'd0);
        chk({tag, "_wc"},    {20'd0, word_count}, 32'd0);
    endtask

    task automatic load41(input string tag, input logic rnd);
        n_writes = 0;
        pulse_start();
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < 7; i++) send(s41[i], rnd ? int'($urandom_range(0, 3)) : 0);
        chk({tag, "_pc1"}, {31'd0, pc_load}, 32'd1);
        chk({tag, "_pcval"}, {20'd0, pc_load_value}, 32'o0200);
        @(posedge clk); #1;
        chk({tag, "_pc0"}, {31'd0, pc_load}, 32'd0);
        chk({tag, "_nw"}, n_writes, 32'd1);
        chk({tag, "_a0"}, {20'd0, log_addr[0]}, 32'o0200);
        chk({tag, "_d0"}, {20'd0, log_data[0]}, 32'o7601);
        chk({tag, "_wc"}, {20'd0, word_count}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rdy0"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_err"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        logic [11:0] a_hold, d_hold;

        // Reset state
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        btnCpuReset = 1'b1;
        @(negedge clk);

        // Basic load
        load41("load", 1'b0);

        // Origin 7777 then two data words, second one wraps to 0000
        n_writes = 0;
        pulse_start();
        chk("restart_done", {31'd0, done}, 32'd0);
        send(8'o200, 0);
        send(8'o177, 0); send(8'o077, 0);
        send(8'o001, 0); send(8'o002, 0);
        send(8'o003, 0); send(8'o004, 0);
        send(8'o200, 0);
        chk("wrap_nw", n_writes, 32'd2);
        chk("wrap_a0", {20'd0, log_addr[0]}, 32'o7777);
        chk("wrap_d0", {20'd0, log_data[0]}, 32'o0102);
        chk("wrap_a1", {20'd0, log_addr[1]}, 32'o0000);
        chk("wrap_d1", {20'd0, log_data[1]}, 32'o0304);
        chk("wrap_wc", {20'd0, word_count}, 32'd2);
        chk("wrap_done", {31'd0, done}, 32'd1);

        // Write latency and 20-cycle memory stall; start while busy is ignored
        n_writes = 0;
        ack_en = 1'b0;
        pulse_start();
        send(8'o200, 0); send(8'o001, 0); send(8'o002, 0);
        chk("lat_e0", {31'd0, mem_write_enable}, 32'd0);
        @(posedge clk); #1;
        chk("lat_e1", {31'd0, mem_write_enable}, 32'd0);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("lat_e2", {31'd0, mem_write_enable}, 32'd1);
        chk("stall_addr0", {20'd0, mem_address}, 32'o0000);
        chk("stall_data0", {20'd0, mem_write_data}, 32'o0102);
        a_hold = mem_address;
        d_hold = mem_write_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) start = 1'b1;
            if (i == 6) start = 1'b0;
            chk("stall_we", {31'd0, mem_write_enable}, 32'd1);
            chk("stall_addr", {20'd0, mem_address}, {20'd0, a_hold});
            chk("stall_data", {20'd0, mem_write_data}, {20'd0, d_hold});
            chk("stall_rdy", {31'd0, byte_ready}, 32'd0);
        end
        ack_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!mem_write_enable) break;
        end
        chk("stall_we_drop", {31'd0, mem_write_enable}, 32'd0);
        chk("stall_nw", n_writes, 32'd1);
        chk("stall_wc", {20'd0, word_count}, 32'd1);
        chk("stall_rdy_back", {31'd0, byte_ready}, 32'd1);
        send(8'o200, 0);
        chk("stall_done", {31'd0, done}, 32'd1);

        // Trailer in place of a low frame
        n_writes = 0;
        pulse_start();
        send(8'o200, 0); send(8'o001, 0); send(8'o200, 0);
        chk("err_flag", {31'd0, error}, 32'd1);
        chk("err_done", {31'd0, done}, 32'd0);
        chk("err_pc", {31'd0, pc_load}, 32'd0);
        chk("err_rdy", {31'd0, byte_ready}, 32'd0);
        @(posedge clk); #1;
        chk("err_pc_late", {31'd0, pc_load}, 32'd0);
        chk("err_nw", n_writes, 32'd0);
        chk("err_hold", {31'd0, error}, 32'd1);

        // Reset while waiting on memory, then a clean gapped load
        ack_en = 1'b0;
        pulse_start();
        send(8'o200, 0); send(8'o001, 0); send(8'o002, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_we", {31'd0, mem_write_enable}, 32'd1);
        @(negedge clk);
        btnCpuReset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        btnCpuReset = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        chk("midrst_nw", n_writes, 32'd0);
        load41("gap", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
